ras_commit_checker: RTL and testbench

//  Downstream consumer of ras_fifo. Pops one queued RAS prediction per committed return.

---
 rtl/ras_commit_checker.sv | 141 ++++++++++++++
 tb/tb_ras_commit_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ras_commit_checker.sv
// Commit-side checker for queued RAS predictions: pops one ras_fifo entry per committed
// return, compares address and sequence tag, and keeps hit/miss/leftover statistics.
module ras_commit_checker #(
    parameter int unsigned WIDTH       = 36,
    parameter int unsigned AW          = 32,
    parameter int unsigned CNT_W       = 32,
    parameter bit          HALT_ON_ERR = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             cmt_valid,
    input  logic             cmt_ret,
    input  logic [AW-1:0]    cmt_target,
    input  logic             drain,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_pop,
    output logic             res_valid,
    output logic             res_miss,
    output logic [AW-1:0]    res_pred,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] left_cnt,
    output logic             err_underflow,
    output logic             err_order,
    output logic [1:0]       state_o,
    output logic             done
);

    localparam int unsigned TAG_W = WIDTH - AW;

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [TAG_W-1:0] exp_tag;
    logic [TAG_W-1:0] head_tag;
    logic [AW-1:0]    head_addr;
    logic             ret;
    logic             tag_bad;
    logic             addr_miss;
    logic             pop_run;
    logic             pop_drain;
    logic             underflow;

    assign head_tag  = fifo_dout[WIDTH-1:AW];
    assign head_addr = fifo_dout[AW-1:0];
    assign ret       = cmt_valid & cmt_ret;
    assign tag_bad   = (head_tag != exp_tag);
    assign addr_miss = (head_addr != cmt_target);

    // Next-state and pop decode; the pop must stay combinational to match the fifo read port.
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        pop_run   = 1'b0;
        pop_drain = 1'b0;
        underflow = 1'b0;
        case (state)
            RUN: begin
                pop_run   = ret & ~fifo_empty;
                underflow = ret & fifo_empty;
                fifo_pop  = pop_run;
                if (HALT_ON_ERR && (underflow || (pop_run && tag_bad))) begin
                    state_nxt = HALT;
                end else if (drain && !ret) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_nxt = DONE;
                end else begin
                    pop_drain = 1'b1;
                    fifo_pop  = 1'b1;
                    if (HALT_ON_ERR && tag_bad) begin
                        state_nxt = HALT;
                    end
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign state_o = state;
    assign done    = (state == DONE);

    // Result, statistics and sticky error registers; counters saturate at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            res_valid     <= 1'b0;
            res_miss      <= 1'b0;
            res_pred      <= '0;
            ret_cnt       <= '0;
            miss_cnt      <= '0;
            left_cnt      <= '0;
            err_underflow <= 1'b0;
            err_order     <= 1'b0;
            exp_tag       <= '0;
        end else begin
            res_valid <= pop_run;
            if (pop_run) begin
                res_pred <= head_addr;
                res_miss <= addr_miss;
                if (ret_cnt != '1) begin
                    ret_cnt <= ret_cnt + CNT_W'(1);
                end
                if (addr_miss && (miss_cnt != '1)) begin
                    miss_cnt <= miss_cnt + CNT_W'(1);
                end
            end
            if (pop_drain && (left_cnt != '1)) begin
                left_cnt <= left_cnt + CNT_W'(1);
            end
            if (fifo_pop) begin
                exp_tag <= exp_tag + TAG_W'(1);
                if (tag_bad) begin
                    err_order <= 1'b1;
                end
            end
            if (underflow) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ras_commit_checker.sv
// Directed bench for ras_commit_checker: the bench plays both the commit stream and the
// ras_fifo read side, and checks each step against hand-computed values.
module tb_ras_commit_checker;

    localparam int unsigned WIDTH = 36;
    localparam int unsigned AW    = 32;
    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             cmt_valid;
    logic             cmt_ret;
    logic [AW-1:0]    cmt_target;
    logic             drain;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_pop;
    logic             res_valid;
    logic             res_miss;
    logic [AW-1:0]    res_pred;
    logic [CNT_W-1:0] ret_cnt;
    logic [CNT_W-1:0] miss_cnt;
    logic [CNT_W-1:0] left_cnt;
    logic             err_underflow;
    logic             err_order;
    logic [1:0]       state_o;
    logic             done;

    int errors = 0;
    int checks = 0;

    ras_commit_checker #(.WIDTH(WIDTH), .AW(AW), .CNT_W(CNT_W), .HALT_ON_ERR(1'b1)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .cmt_valid(cmt_valid), .cmt_ret(cmt_ret), .cmt_target(cmt_target),
        .drain(drain), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_pop(fifo_pop), .res_valid(res_valid), .res_miss(res_miss), .res_pred(res_pred),
        .ret_cnt(ret_cnt), .miss_cnt(miss_cnt), .left_cnt(left_cnt),
        .err_underflow(err_underflow), .err_order(err_order),
        .state_o(state_o), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic entry(input logic [3:0] tag, input logic [AW-1:0] addr);
        fifo_empty = 1'b0;
        fifo_dout  = {tag, addr};
    endtask

    task automatic idle();
        cmt_valid  = 1'b0;
        cmt_ret    = 1'b0;
        drain      = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
    endtask

    task automatic do_clr();
        idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; cmt_target = '0;
        idle();
        step();
        step();
        rst = 1'b0;
        #1;

        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_ret_cnt", 64'(ret_cnt), 64'd0);
        chk("rst_errs", 64'({err_underflow, err_order}), 64'd0);
        chk("rst_pop", 64'(fifo_pop), 64'd0);

        // T1: two matching returns back to back
        cmt_valid = 1'b1; cmt_ret = 1'b1; cmt_target = 32'h1000;
        entry(4'd0, 32'h1000);
        #1;
        chk("t1_pop0", 64'(fifo_pop), 64'd1);
        step();
        chk("t1_valid0", 64'(res_valid), 64'd1);
        chk("t1_miss0", 64'(res_miss), 64'd0);
        chk("t1_pred0", 64'(res_pred), 64'h1000);
        cmt_target = 32'h2000;
        entry(4'd1, 32'h2000);
        #1;
        chk("t1_pop1", 64'(fifo_pop), 64'd1);
        step();
        chk("t1_valid1", 64'(res_valid), 64'd1);
        chk("t1_miss1", 64'(res_miss), 64'd0);
        chk("t1_pred1", 64'(res_pred), 64'h2000);
        idle();
        step();
        chk("t1_valid_off", 64'(res_valid), 64'd0);
        chk("t1_ret_cnt", 64'(ret_cnt), 64'd2);
        chk("t1_miss_cnt", 64'(miss_cnt), 64'd0);
        chk("t1_state", 64'(state_o), 64'd0);

        // Non-return commit must not pop
        cmt_valid = 1'b1; cmt_ret = 1'b0;
        entry(4'd2, 32'h3000);
        #1;
        chk("nonret_pop", 64'(fifo_pop), 64'd0);
        step();
        chk("nonret_valid", 64'(res_valid), 64'd0);

        // T2: address mismatch after a clear (exp_tag back to 0)
        do_clr();
        chk("clr_ret_cnt", 64'(ret_cnt), 64'd0);
        cmt_valid = 1'b1; cmt_ret = 1'b1; cmt_target = 32'h1004;
        entry(4'd0, 32'h1000);
        step();
        idle();
        chk("t2_valid", 64'(res_valid), 64'd1);
        chk("t2_miss", 64'(res_miss), 64'd1);
        chk("t2_pred", 64'(res_pred), 64'h1000);
        chk("t2_miss_cnt", 64'(miss_cnt), 64'd1);
        chk("t2_ret_cnt", 64'(ret_cnt), 64'd1);
        chk("t2_errs", 64'({err_underflow, err_order}), 64'd0);
        chk("t2_state", 64'(state_o), 64'd0);

        // T3: underflow halts; later returns ignored
        do_clr();
        cmt_valid = 1'b1; cmt_ret = 1'b1; cmt_target = 32'h1000;
        #1;
        chk("t3_pop_empty", 64'(fifo_pop), 64'd0);
        step();
        chk("t3_underflow", 64'(err_underflow), 64'd1);
        chk("t3_state", 64'(state_o), 64'd3);
        chk("t3_valid", 64'(res_valid), 64'd0);
        entry(4'd0, 32'h1000);
        #1;
        chk("t3_halt_pop", 64'(fifo_pop), 64'd0);
        step();
        chk("t3_halt_ret_cnt", 64'(ret_cnt), 64'd0);
        chk("t3_halt_valid", 64'(res_valid), 64'd0);

        // T4: tag out of order halts, but the erroring return is still counted
        do_clr();
        chk("clr_state", 64'(state_o), 64'd0);
        chk("clr_underflow", 64'(err_underflow), 64'd0);
        cmt_valid = 1'b1; cmt_ret = 1'b1; cmt_target = 32'h1000;
        entry(4'd3, 32'h1000);
        step();
        chk("t4_order", 64'(err_order), 64'd1);
        chk("t4_state", 64'(state_o), 64'd3);
        chk("t4_ret_cnt", 64'(ret_cnt), 64'd1);
        chk("t4_valid", 64'(res_valid), 64'd1);
        step();
        chk("t4_halt_valid", 64'(res_valid), 64'd0);
        chk("t4_halt_ret_cnt", 64'(ret_cnt), 64'd1);

        // T5: 17 in-order pops wrap the expected tag 15 -> 0
        do_clr();
        for (int i = 0; i < 17; i++) begin
            cmt_valid = 1'b1; cmt_ret = 1'b1; cmt_target = 32'h100 + 32'(i);
            entry(4'(i), 32'h100 + 32'(i));
            step();
        end
        idle();
        chk("t5_order", 64'(err_order), 64'd0);
        chk("t5_ret_cnt", 64'(ret_cnt), 64'd17);
        chk("t5_pred", 64'(res_pred), 64'h110);
        chk("t5_state", 64'(state_o), 64'd0);

        // Return coinciding with drain: return handled first, DRAIN the cycle after
        do_clr();
        cmt_valid = 1'b1; cmt_ret = 1'b1; cmt_target = 32'h40; drain = 1'b1;
        entry(4'd0, 32'h40);
        step();
        chk("rd_state_run", 64'(state_o), 64'd0);
        chk("rd_valid", 64'(res_valid), 64'd1);
        cmt_valid = 1'b0; cmt_ret = 1'b0; fifo_empty = 1'b1;
        step();
        chk("rd_state_drain", 64'(state_o), 64'd1);

        // T6: drain three leftovers, then clear
        do_clr();
        drain = 1'b1;
        entry(4'd0, 32'hA0);
        #1;
        chk("t6_run_nopop", 64'(fifo_pop), 64'd0);
        step();
        chk("t6_state_drain", 64'(state_o), 64'd1);
        for (int i = 0; i < 3; i++) begin
            entry(4'(i), 32'hA0 + 32'(i));
            cmt_valid = 1'b1; cmt_ret = 1'b1;
            #1;
            chk("t6_pop", 64'(fifo_pop), 64'd1);
            step();
        end
        fifo_empty = 1'b1;
        #1;
        chk("t6_empty_pop", 64'(fifo_pop), 64'd0);
        step();
        chk("t6_done", 64'(done), 64'd1);
        chk("t6_state_done", 64'(state_o), 64'd2);
        chk("t6_left_cnt", 64'(left_cnt), 64'd3);
        chk("t6_ret_cnt", 64'(ret_cnt), 64'd0);
        chk("t6_order", 64'(err_order), 64'd0);
        chk("t6_valid", 64'(res_valid), 64'd0);
        entry(4'd3, 32'hB0);
        #1;
        chk("t6_done_pop", 64'(fifo_pop), 64'd0);
        do_clr();
        chk("t6_clr_left", 64'(left_cnt), 64'd0);
        chk("t6_clr_state", 64'(state_o), 64'd0);
        chk("t6_clr_done", 64'(done), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
